algo_mrnw_maptbl_mem: RTL
=========================

Name: algo_mrnw_maptbl_mem

Overview:
- Parametrised multi-read / multi-write map-table memory for the algo_mrnw family.
- Replaces the fixed inline behavioural map-table storage in each top_wrap.
- Adds over the previous generation: configurable port counts, width, depth and latency; a reset-time init sequencer with a ready handshake; deterministic same-row write-collision resolution; optional read-during-write bypass.
- Instantiated once per top_wrap and driven by the algo top's map-table ports.

Parameters:
- NUMRDPT, 9, number of read ports.
- NUMWRPT, 7, number of write ports.
- WIDTH, 8, row width in bits (BITPBNK*NUMVBNK at instantiation).
- NUMVROW, 2048, number of rows.
- BITVROW, 11, row address width; must satisfy 2^BITVROW >= NUMVROW.
- FLOPIN, 1, input register stages, 0 or 1.
- MEMDLY, 1, output register stages, 1..3.
- BYPASS, 0, 1 = a read returns data written to the same row in the same sampled cycle.
- INITVAL, 0, WIDTH-bit value written to every row during init.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- ready  out  1  init complete; requests are accepted only while high.
- write  in  NUMWRPT  per-port write enable.
- wr_adr  in  NUMWRPT*BITVROW  write row, packed, port 0 in the LSBs.
- din  in  NUMWRPT*WIDTH  write data, packed.
- read  in  NUMRDPT  per-port read enable.
- rd_adr  in  NUMRDPT*BITVROW  read row, packed.
- rd_vld  out  NUMRDPT  read data valid, per port.
- rd_dout  out  NUMRDPT*WIDTH  read data, packed.
- wr_coll  out  1  pulse: two or more accepted writes targeted the same row in one cycle.

Behaviour:
- Reset state: all flops cleared; ready=0, rd_vld=0, rd_dout=0, wr_coll=0; FSM in INIT with init row counter=0. Array contents are not reset.
- FSM INIT:
  - Writes INITVAL to row cnt each cycle; cnt increments.
  - On cnt==NUMVROW-1: write that row, go to DONE.
  - ready rises on the first cycle in DONE, i.e. NUMVROW cycles after rst deasserts.
- FSM DONE: stays until rst. rst asserted at any time, including mid-init, returns to INIT with cnt=0; the walk restarts from row 0.
- Gating: while ready=0, write and read inputs are ignored. Writes are dropped; reads produce no rd_vld.
- Sampled cycle S: the cycle requests are taken (FLOPIN=0) or the cycle after they are registered (FLOPIN=1).
- Write commit: memory updated at the clock edge ending cycle S.
- Write collision, same row in cycle S:
  - the highest-indexed port wins;
  - wr_coll=1 for exactly one cycle, cycle S+1;
  - no error otherwise.
- Read timing: address taken in cycle S, array read combinationally, then MEMDLY output stages.
  - rd_vld[i] and rd_dout[i] appear exactly FLOPIN+MEMDLY cycles after the request cycle.
  - rd_vld is high for one cycle per accepted read.
  - rd_dout holds its last value when rd_vld=0.
- Read/write to the same row in the same S:
  - BYPASS=0: returns the pre-write contents.
  - BYPASS=1: returns the winning write's data.
  - Reads after cycle S always see the committed data.
- Out-of-range rows (adr >= NUMVROW): write dropped; read returns 0 with rd_vld=1.
- Widths: packed buses are sliced as [i*W +: W]; no arithmetic beyond the init counter, which is BITVROW+1 bits wide to detect terminal count.

Decomposition:
- Package algo_mrnw_pkg:
  - FSM state enum (ST_INIT, ST_DONE);
  - port-slice helper function;
  - default constant for MEMDLY bounds.
- Sub-module algo_mrnw_maptbl_pipe: a parametrised WIDTH x STAGES register shift pipe with valid and async reset. Used for the input flop, per FLOPIN, and the output stages, per MEMDLY.
- Array, collision resolution and FSM stay in the top module.

Test Plan:
- Init: NUMVROW=16, INITVAL=8'hA5; release rst at cycle 0 -> ready=0 for cycles 0..15, ready=1 at cycle 16; reading rows 0..15 returns 8'hA5.
- Mid-init reset: assert rst at init cycle 7 for 2 cycles -> ready stays 0; ready rises 16 cycles after the second deassert.
- Latency: FLOPIN=1, MEMDLY=2; write row 3 = 8'h3C at cycle T; read row 3 at T+1 -> rd_vld[0]=1 with 8'h3C at T+4, and rd_vld=0 at every other cycle.
- Collision: ports 1 and 5 both write row 9 (8'h11, 8'h55) in one cycle -> wr_coll pulses once; a later read of row 9 returns 8'h55.
- Bypass: write row 4 = 8'h77 and read row 4 in the same cycle (old value 8'hA5) -> BYPASS=0 returns 8'hA5; BYPASS=1 returns 8'h77.
- Gating: all 7 write ports and 9 read ports asserted during init -> no rd_vld, and memory still equals INITVAL after ready.

Source files
------------

// File: rtl/algo_mrnw_pkg.sv
// Shared types and helpers for the algo_mrnw map-table memory.
package algo_mrnw_pkg;

  // Init sequencer states: walk every row with the init value, then serve requests.
  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_DONE = 1'b1
  } maptbl_state_e;

  // Legal range of output register stages.
  localparam int MEMDLY_MIN = 1;
  localparam int MEMDLY_MAX = 3;

  // Low bit of port 'port' inside a packed bus of 'width'-bit fields.
  function automatic int port_lo(input int port, input int width);
    return port * width;
  endfunction

  // Pull an out-of-range output stage count back into the legal range.
  function automatic int clamp_memdly(input int dly);
    if (dly < MEMDLY_MIN) begin
      return MEMDLY_MIN;
    end else if (dly > MEMDLY_MAX) begin
      return MEMDLY_MAX;
    end else begin
      return dly;
    end
  endfunction

endpackage

// File: rtl/algo_mrnw_maptbl_pipe.sv
// Register shift pipe with a valid bit. Data in each stage only advances
// with a valid beat, so the last stage holds the most recent valid data.
// STAGES=0 degenerates to a wire.
module algo_mrnw_maptbl_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_data
);

  if (STAGES == 0) begin : g_thru
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign out_vld  = in_vld;
    assign out_data = in_data;
  end else begin : g_reg
    logic [STAGES-1:0] vld_r;
    logic [WIDTH-1:0]  data_r [STAGES];

    // Shift valid every cycle; move data only alongside a valid beat.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_r <= {STAGES{1'b0}};
        for (int k = 0; k < STAGES; k++) begin
          data_r[k] <= {WIDTH{1'b0}};
        end
      end else begin
        vld_r[0] <= in_vld;
        if (in_vld) begin
          data_r[0] <= in_data;
        end
        for (int k = 1; k < STAGES; k++) begin
          vld_r[k] <= vld_r[k-1];
          if (vld_r[k-1]) begin
            data_r[k] <= data_r[k-1];
          end
        end
      end
    end

    assign out_vld  = vld_r[STAGES-1];
    assign out_data = data_r[STAGES-1];
  end

endmodule

// File: rtl/algo_mrnw_maptbl_mem.sv
// Multi-read / multi-write map-table memory with reset-time init walk,
// highest-port-wins write collision resolution and optional read bypass.
module algo_mrnw_maptbl_mem
  import algo_mrnw_pkg::*;
#(
  parameter int NUMRDPT = 9,
  parameter int NUMWRPT = 7,
  parameter int WIDTH   = 8,
  parameter int NUMVROW = 2048,
  parameter int BITVROW = 11,
  parameter int FLOPIN  = 1,
  parameter int MEMDLY  = 1,
  parameter int BYPASS  = 0,
  parameter logic [WIDTH-1:0] INITVAL = {WIDTH{1'b0}}
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       ready,
  input  logic [NUMWRPT-1:0]         write,
  input  logic [NUMWRPT*BITVROW-1:0] wr_adr,
  input  logic [NUMWRPT*WIDTH-1:0]   din,
  input  logic [NUMRDPT-1:0]         read,
  input  logic [NUMRDPT*BITVROW-1:0] rd_adr,
  output logic [NUMRDPT-1:0]         rd_vld,
  output logic [NUMRDPT*WIDTH-1:0]   rd_dout,
  output logic                       wr_coll
);

  localparam int INSTG  = (FLOPIN != 0) ? 1 : 0;
  localparam int OUTSTG = clamp_memdly(MEMDLY);
  localparam int LAST_I = NUMVROW - 1;
  localparam logic [BITVROW:0] ROW_LIM  = NUMVROW[BITVROW:0];
  localparam logic [BITVROW:0] ROW_LAST = LAST_I[BITVROW:0];
  localparam logic [BITVROW:0] CNT_ONE  = {{BITVROW{1'b0}}, 1'b1};

  // Request bundle layout: {read, rd_adr, write, wr_adr, din}
  localparam int W_DIN  = NUMWRPT * WIDTH;
  localparam int W_WA   = NUMWRPT * BITVROW;
  localparam int W_RA   = NUMRDPT * BITVROW;
  localparam int OFF_WA = W_DIN;
  localparam int OFF_WE = OFF_WA + W_WA;
  localparam int OFF_RA = OFF_WE + NUMWRPT;
  localparam int OFF_RE = OFF_RA + W_RA;
  localparam int REQW   = OFF_RE + NUMRDPT;

  maptbl_state_e state_r, state_nxt;
  logic [BITVROW:0] cnt_r, cnt_nxt;

  logic [WIDTH-1:0] mem [NUMVROW];

  logic [REQW-1:0] req_in_s, req_q_s;
  logic            req_vld_s;
  logic [NUMWRPT-1:0] we_q_s;
  logic [W_WA-1:0]    wr_adr_q_s;
  logic [W_DIN-1:0]   din_q_s;
  logic [NUMRDPT-1:0] re_q_s;
  logic [W_RA-1:0]    rd_adr_q_s;

  logic [BITVROW-1:0] wa_s [NUMWRPT];
  logic [WIDTH-1:0]   wd_s [NUMWRPT];
  logic [NUMWRPT-1:0] wv_s;
  logic [BITVROW-1:0] ra_s [NUMRDPT];
  logic [WIDTH-1:0]   rd_data_s [NUMRDPT];
  logic               coll_s;

  assign ready = (state_r == ST_DONE);

  // Init sequencer state and row counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_INIT;
      cnt_r   <= {(BITVROW+1){1'b0}};
    end else begin
      state_r <= state_nxt;
      cnt_r   <= cnt_nxt;
    end
  end

  // Walk rows 0..NUMVROW-1, then park in DONE until the next reset.
  always_comb begin
    state_nxt = state_r;
    cnt_nxt   = cnt_r;
    case (state_r)
      ST_INIT: begin
        if (cnt_r == ROW_LAST) begin
          state_nxt = ST_DONE;
        end else begin
          cnt_nxt = cnt_r + CNT_ONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_DONE;
      end
      default: begin
        state_nxt = ST_INIT;
        cnt_nxt   = {(BITVROW+1){1'b0}};
      end
    endcase
  end

  // Requests are dropped before the optional input flop while not ready.
  assign req_in_s = {read & {NUMRDPT{ready}}, rd_adr,
                     write & {NUMWRPT{ready}}, wr_adr, din};

  algo_mrnw_maptbl_pipe #(.WIDTH(REQW), .STAGES(INSTG)) u_in (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (1'b1),
    .in_data  (req_in_s),
    .out_vld  (req_vld_s),
    .out_data (req_q_s)
  );

  assign din_q_s    = req_q_s[0 +: W_DIN];
  assign wr_adr_q_s = req_q_s[OFF_WA +: W_WA];
  assign we_q_s     = req_q_s[OFF_WE +: NUMWRPT] & {NUMWRPT{req_vld_s}};
  assign rd_adr_q_s = req_q_s[OFF_RA +: W_RA];
  assign re_q_s     = req_q_s[OFF_RE +: NUMRDPT] & {NUMRDPT{req_vld_s}};

  // Split sampled buses per port; out-of-range writes are not accepted.
  always_comb begin
    for (int j = 0; j < NUMWRPT; j++) begin
      wa_s[j] = wr_adr_q_s[port_lo(j, BITVROW) +: BITVROW];
      wd_s[j] = din_q_s[port_lo(j, WIDTH) +: WIDTH];
      wv_s[j] = we_q_s[j] && ({1'b0, wa_s[j]} < ROW_LIM);
    end
    for (int i = 0; i < NUMRDPT; i++) begin
      ra_s[i] = rd_adr_q_s[port_lo(i, BITVROW) +: BITVROW];
    end
  end

  // Flag any pair of accepted writes hitting the same row.
  always_comb begin
    coll_s = 1'b0;
    for (int j = 0; j < NUMWRPT; j++) begin
      for (int k = j + 1; k < NUMWRPT; k++) begin
        coll_s = coll_s | (wv_s[j] & wv_s[k] & (wa_s[j] == wa_s[k]));
      end
    end
  end

  // Collision pulse lands in the cycle after the sampled cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_coll <= 1'b0;
    end else begin
      wr_coll <= coll_s;
    end
  end

  // Array update: init walk, else accepted writes with the last port winning.
  always_ff @(posedge clk) begin
    if (state_r == ST_INIT) begin
      mem[cnt_r[BITVROW-1:0]] <= INITVAL;
    end else begin
      for (int j = 0; j < NUMWRPT; j++) begin
        if (wv_s[j]) begin
          mem[wa_s[j]] <= wd_s[j];
        end
      end
    end
  end

  // Combinational array read, with optional same-cycle write forwarding.
  always_comb begin
    for (int i = 0; i < NUMRDPT; i++) begin
      if ({1'b0, ra_s[i]} < ROW_LIM) begin
        rd_data_s[i] = mem[ra_s[i]];
      end else begin
        rd_data_s[i] = {WIDTH{1'b0}};
      end
      for (int j = 0; j < NUMWRPT; j++) begin
        if ((BYPASS != 0) && wv_s[j] && (wa_s[j] == ra_s[i])) begin
          rd_data_s[i] = wd_s[j];
        end else begin
          rd_data_s[i] = rd_data_s[i];
        end
      end
    end
  end

  for (genvar i = 0; i < NUMRDPT; i++) begin : g_rdout
    algo_mrnw_maptbl_pipe #(.WIDTH(WIDTH), .STAGES(OUTSTG)) u_out (
      .clk      (clk),
      .rst      (rst),
      .in_vld   (re_q_s[i]),
      .in_data  (rd_data_s[i]),
      .out_vld  (rd_vld[i]),
      .out_data (rd_dout[port_lo(i, WIDTH) +: WIDTH])
    );
  end

endmodule
